// File: rtl/touch_key_decoder.sv
// Touch key decoder: classifies two cap1188 key bitmaps, debounces them, and emits tone codes and function-key pulses.
// Optional auto-repeat of up/down pulses is built when TOUCH_KEY_AUTO_REPEAT_EN is defined.
module touch_key_decoder #(
    parameter int DEBOUNCE_CYCLES = 240000,
    parameter int REPEAT_DELAY    = 6000000,
    parameter int REPEAT_PERIOD   = 1200000
) (
    input  logic       clk_in,
    input  logic       rst_in,
    input  logic [7:0] sensor_data1,
    input  logic [7:0] sensor_data2,
    output logic [7:0] tone,
    output logic       tone_en,
    output logic       down_pulse,
    output logic       up_pulse,
    output logic       mode_pulse,
    output logic [1:0] repeat_state
);

    localparam int DW = 20;
    localparam int RW = 24;
    localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);

    if (DEBOUNCE_CYCLES < 2 || DEBOUNCE_CYCLES > (1 << DW) - 1) begin : g_bad_debounce
        $error("DEBOUNCE_CYCLES out of range");
    end
    if (REPEAT_DELAY < 1 || REPEAT_PERIOD < 1 || REPEAT_DELAY > (1 << RW) - 1
        || REPEAT_PERIOD > (1 << RW) - 1) begin : g_bad_repeat
        $error("REPEAT_DELAY/REPEAT_PERIOD out of range");
    end

    typedef enum logic [2:0] {
        CLS_NONE = 3'd0,
        CLS_TONE = 3'd1,
        CLS_DOWN = 3'd2,
        CLS_UP   = 3'd3,
        CLS_MODE = 3'd4
    } key_class_t;

    key_class_t raw_class, cand_class, stable_class;
    logic [7:0] raw_code, cand_code, stable_code;
    logic [DW-1:0] db_cnt;
    logic same, accept, class_change, rep_fire;

    // The first sensor always wins; the second sensor's tone keys are active-low coded.
    always_comb begin
        raw_class = CLS_NONE;
        raw_code  = 8'h00;
        if (sensor_data1 != 8'h00) begin
            raw_class = CLS_TONE;
            raw_code  = sensor_data1;
        end else begin
            case (sensor_data2)
                8'h00: raw_class = CLS_NONE;
                8'h20: raw_class = CLS_DOWN;
                8'h40: raw_class = CLS_UP;
                8'h80: raw_class = CLS_MODE;
                default: begin
                    raw_class = CLS_TONE;
                    raw_code  = ~sensor_data2;
                end
            endcase
        end
    end

    assign same         = (raw_class == cand_class) && (raw_code == cand_code);
    assign accept       = same && (db_cnt == DB_LAST)
                          && ((cand_class != stable_class) || (cand_code != stable_code));
    assign class_change = accept && (cand_class != stable_class);

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            cand_class   <= CLS_NONE;
            cand_code    <= 8'h00;
            db_cnt       <= '0;
            stable_class <= CLS_NONE;
            stable_code  <= 8'h00;
            down_pulse   <= 1'b0;
            up_pulse     <= 1'b0;
            mode_pulse   <= 1'b0;
        end else begin
            if (!same) begin
                cand_class <= raw_class;
                cand_code  <= raw_code;
                db_cnt     <= '0;
            end else if (db_cnt != DB_LAST) begin
                db_cnt <= db_cnt + 1'b1;
            end
            if (accept) begin
                stable_class <= cand_class;
                stable_code  <= cand_code;
            end
            // rep_fire is never raised on a class-change edge, so at most one pulse is set.
            down_pulse <= (class_change && cand_class == CLS_DOWN)
                          || (rep_fire && stable_class == CLS_DOWN);
            up_pulse   <= (class_change && cand_class == CLS_UP)
                          || (rep_fire && stable_class == CLS_UP);
            mode_pulse <= class_change && cand_class == CLS_MODE;
        end
    end

    assign tone    = (stable_class == CLS_TONE) ? stable_code : 8'h00;
    assign tone_en = (tone != 8'h00);

`ifdef TOUCH_KEY_AUTO_REPEAT_EN
    typedef enum logic [1:0] {
        R_IDLE   = 2'd0,
        R_DELAY  = 2'd1,
        R_REPEAT = 2'd2
    } rep_state_t;

    rep_state_t r_state, r_next;
    logic [RW-1:0] r_cnt, r_cnt_next;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_state <= R_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= r_next;
            r_cnt   <= r_cnt_next;
        end
    end

    // Any stable class change restarts the FSM; only up/down arm it, so mode never repeats.
    always_comb begin
        r_next     = r_state;
        r_cnt_next = r_cnt + 1'b1;
        rep_fire   = 1'b0;
        if (class_change) begin
            r_cnt_next = '0;
            r_next     = (cand_class == CLS_UP || cand_class == CLS_DOWN) ? R_DELAY : R_IDLE;
        end else begin
            case (r_state)
                R_IDLE: r_cnt_next = '0;
                R_DELAY: begin
                    if (r_cnt == RW'(REPEAT_DELAY - 1)) begin
                        rep_fire   = 1'b1;
                        r_next     = R_REPEAT;
                        r_cnt_next = '0;
                    end
                end
                R_REPEAT: begin
                    if (r_cnt == RW'(REPEAT_PERIOD - 1)) begin
                        rep_fire   = 1'b1;
                        r_cnt_next = '0;
                    end
                end
                default: begin
                    r_next     = R_IDLE;
                    r_cnt_next = '0;
                end
            endcase
        end
    end

    assign repeat_state = r_state;
`else
    assign rep_fire     = 1'b0;
    assign repeat_state = 2'd0;
`endif

endmodule

// File: tb/tb_touch_key_decoder.sv
// Bench for touch_key_decoder with short debounce/repeat timing; expectations follow TOUCH_KEY_AUTO_REPEAT_EN.
module tb_touch_key_decoder;

    localparam int W = 44;

    logic       clk_in = 1'b0;
    logic       rst_in = 1'b1;
    logic [7:0] sensor_data1 = 8'h00;
    logic [7:0] sensor_data2 = 8'h00;
    logic [7:0] tone;
    logic       tone_en, down_pulse, up_pulse, mode_pulse;
    logic [1:0] repeat_state;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    bit mon_en   = 1'b0;
    logic [11:0]  prev_obs = '0;
    logic [W-1:0] exp_q[$];

`ifdef TOUCH_KEY_AUTO_REPEAT_EN
    localparam bit REP = 1'b1;
`else
    localparam bit REP = 1'b0;
`endif

    touch_key_decoder #(
        .DEBOUNCE_CYCLES(4),
        .REPEAT_DELAY(10),
        .REPEAT_PERIOD(3)
    ) dut (
        .clk_in(clk_in),
        .rst_in(rst_in),
        .sensor_data1(sensor_data1),
        .sensor_data2(sensor_data2),
        .tone(tone),
        .tone_en(tone_en),
        .down_pulse(down_pulse),
        .up_pulse(up_pulse),
        .mode_pulse(mode_pulse),
        .repeat_state(repeat_state)
    );

    // Clock and cycle counter: cyc equals the number of rising edges seen.
    always #5 clk_in = ~clk_in;
    always @(posedge clk_in) cyc <= cyc + 1;

    function automatic logic [11:0] v(input logic [7:0] t, input logic d, input logic u, input logic m);
        return {t, (t != 8'h00), d, u, m};
    endfunction

    task automatic push_exp(input int c, input logic [11:0] o);
        exp_q.push_back({32'(c), o});
    endtask

    task automatic at(input int c);
        while (cyc < c) @(negedge clk_in);
    endtask

    task automatic drive(input logic [7:0] d1, input logic [7:0] d2);
        sensor_data1 = d1;
        sensor_data2 = d2;
    endtask

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: every change of the output vector must match the next expected event.
    always @(negedge clk_in) begin
        logic [11:0]  obs;
        logic [W-1:0] e;
        if (mon_en) begin
            obs = {tone, tone_en, down_pulse, up_pulse, mode_pulse};
            n_checks++;
            if ((32'(down_pulse) + 32'(up_pulse) + 32'(mode_pulse)) > 1) begin
                n_fail++;
                $display("FAIL pulse_onehot: got %b%b%b at cycle %0d", down_pulse, up_pulse, mode_pulse, cyc);
            end
            if (obs != prev_obs) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_event: got %h at cycle %0d, none expected", obs, cyc);
                end else begin
                    e = exp_q.pop_front();
                    if (e != {32'(cyc), obs}) begin
                        n_fail++;
                        $display("FAIL event: got cycle %0d value %h expected cycle %0d value %h",
                                 cyc, obs, e[W-1:12], e[11:0]);
                    end
                end
                prev_obs = obs;
            end
        end
    end

    initial begin
        // Reset state
        at(3);
        check("reset_tone", 16'(tone), 16'h00);
        check("reset_tone_en", 16'(tone_en), 16'h0);
        check("reset_pulses", 16'({down_pulse, up_pulse, mode_pulse}), 16'h0);
        check("reset_repeat_state", 16'(repeat_state), 16'h0);
        rst_in = 1'b0;
        mon_en = 1'b1;

        // Plain tone press and release
        at(5);   drive(8'h04, 8'h00); push_exp(10, v(8'h04, 0, 0, 0));
        at(14);  drive(8'h00, 8'h00); push_exp(19, v(8'h00, 0, 0, 0));

        // Bouncing contact never settles
        for (int i = 0; i < 10; i++) begin
            at(22 + 2 * i);
            drive((i % 2 == 0) ? 8'h01 : 8'h00, 8'h00);
        end

        // Mode key pulses once only
        at(46);  drive(8'h00, 8'h80);
        push_exp(51, v(8'h00, 0, 0, 1)); push_exp(52, v(8'h00, 0, 0, 0));
        at(77);  drive(8'h00, 8'h00);

        // Second-sensor tone inversion, sensor1 priority over up key, tone-to-tone change
        at(84);  drive(8'h00, 8'h11); push_exp(89, v(8'hEE, 0, 0, 0));
        at(94);  drive(8'h02, 8'h40); push_exp(99, v(8'h02, 0, 0, 0));
        at(104); drive(8'h00, 8'h00); push_exp(109, v(8'h00, 0, 0, 0));

        // Up key held for 26 cycles
        at(114); drive(8'h00, 8'h40);
        push_exp(119, v(8'h00, 0, 1, 0)); push_exp(120, v(8'h00, 0, 0, 0));
        if (REP) begin
            for (int t = 129; t <= 144; t += 3) begin
                push_exp(t, v(8'h00, 0, 1, 0));
                push_exp(t + 1, v(8'h00, 0, 0, 0));
            end
        end
        at(140); drive(8'h00, 8'h00);

        // Up directly to down, then reset while down repeats
        at(150); drive(8'h00, 8'h40);
        push_exp(155, v(8'h00, 0, 1, 0)); push_exp(156, v(8'h00, 0, 0, 0));
        at(159); drive(8'h00, 8'h20);
        push_exp(164, v(8'h00, 1, 0, 0)); push_exp(165, v(8'h00, 0, 0, 0));
        if (REP) begin
            push_exp(174, v(8'h00, 1, 0, 0)); push_exp(175, v(8'h00, 0, 0, 0));
        end
        push_exp(182, v(8'h00, 1, 0, 0)); push_exp(183, v(8'h00, 0, 0, 0));
        at(176); rst_in = 1'b1;
        at(177);
        check("rst_mid_tone", 16'(tone), 16'h00);
        check("rst_mid_pulses", 16'({tone_en, down_pulse, up_pulse, mode_pulse}), 16'h0);
        check("rst_mid_repeat_state", 16'(repeat_state), 16'h0);
        rst_in = 1'b0;
        at(184); drive(8'h00, 8'h00);

        // Chord passes through unmodified
        at(195); drive(8'h81, 8'h00); push_exp(200, v(8'h81, 0, 0, 0));
        at(205); drive(8'h00, 8'h00); push_exp(210, v(8'h00, 0, 0, 0));

        // Change mid-debounce restarts the count
        at(215); drive(8'h10, 8'h00);
        at(218); drive(8'h20, 8'h00); push_exp(223, v(8'h20, 0, 0, 0));
        at(230); drive(8'h00, 8'h00); push_exp(235, v(8'h00, 0, 0, 0));

        at(245);
        check("queue_drained", 16'(exp_q.size()), 16'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
